// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci job sequencer.
//   fibo_state_e     : controller FSM states
//   FIBO_DATA_W      : generator term width
//   FIBO_COUNT_W     : skip/count field and counter width
//   FIBO_FIRST_TERM  : generator term after reset
//   FIBO_SECOND_TERM : generator term after the first step
package fibo_pkg;

    localparam int FIBO_DATA_W  = 8;
    localparam int FIBO_COUNT_W = 8;

    localparam logic [FIBO_DATA_W-1:0] FIBO_FIRST_TERM  = 8'd0;
    localparam logic [FIBO_DATA_W-1:0] FIBO_SECOND_TERM = 8'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } fibo_state_e;

endpackage

// File: rtl/fibo_term_counter.sv
// Loadable down-counter used for the skip and emit term counts.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (count -> 0)
//   load        : load load_value (has priority over dec)
//   load_value  : value to load
//   dec         : decrement by one
//   count       : current count
//   is_one      : count == 1 (the controller leaves a state on this value)
module fibo_term_counter
    import fibo_pkg::*;
#(
    parameter int COUNT_W = FIBO_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    input  logic               dec,
    output logic [COUNT_W-1:0] count,
    output logic               is_one
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            // The zero guard keeps the counter from wrapping even if dec is
            // ever raised on an empty count.
            count <= count - COUNT_W'(1);
        end
    end

    assign is_one = (count == COUNT_W'(1));

endmodule

// File: rtl/fibo_seq_ctrl.sv
// Job sequencer for the Fibonacci generator: accepts "discard S terms, then
// emit N terms" jobs and is the only agent that steps the generator.
// Handshakes: a transfer happens on a rising edge where valid && ready.
// req_valid/req_skip/req_count are held by the requester until req_ready;
// out_valid, once raised, stays high with out_data/out_last stable until
// out_ready is seen.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : job request handshake
//   req_skip, req_count           : terms to discard, terms to emit
//   gen_step                      : generator advances on the next edge
//   gen_value                     : generator's current term
//   out_valid/out_ready           : output stream handshake
//   out_data, out_last            : emitted term, final beat of the job
//   done                          : one-cycle pulse at job completion
//   busy                          : a job is in progress
module fibo_seq_ctrl
    import fibo_pkg::*;
#(
    parameter int DATA_W  = FIBO_DATA_W,
    parameter int COUNT_W = FIBO_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COUNT_W-1:0] req_skip,
    input  logic [COUNT_W-1:0] req_count,
    output logic               gen_step,
    input  logic [DATA_W-1:0]  gen_value,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_last,
    output logic               done,
    output logic               busy
);

    fibo_state_e state;
    fibo_state_e state_next;

    logic               accept;
    logic               skip_dec;
    logic               emit_dec;
    logic [COUNT_W-1:0] skip_cnt;
    logic [COUNT_W-1:0] emit_cnt;
    logic               skip_is_one;
    logic               emit_is_one;

    fibo_term_counter #(.COUNT_W(COUNT_W)) u_skip_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (req_skip),
        .dec        (skip_dec),
        .count      (skip_cnt),
        .is_one     (skip_is_one)
    );

    fibo_term_counter #(.COUNT_W(COUNT_W)) u_emit_cnt (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (req_count),
        .dec        (emit_dec),
        .count      (emit_cnt),
        .is_one     (emit_is_one)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        skip_dec   = 1'b0;
        emit_dec   = 1'b0;
        gen_step   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        done       = 1'b0;
        busy       = 1'b1;

        case (state)
            IDLE: begin
                busy      = 1'b0;
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    if (req_skip != '0) begin
                        state_next = SKIP;
                    end else if (req_count != '0) begin
                        state_next = EMIT;
                    end else begin
                        state_next = FIN;
                    end
                end
            end

            SKIP: begin
                // Discarded terms need no consumer, so stepping is unconditional.
                gen_step = 1'b1;
                skip_dec = 1'b1;
                if (skip_is_one) begin
                    state_next = (emit_cnt != '0) ? EMIT : FIN;
                end
            end

            EMIT: begin
                out_valid = 1'b1;
                out_data  = gen_value;
                out_last  = emit_is_one;
                // The generator only moves on an accepted beat, which keeps
                // out_data stable under backpressure.
                gen_step  = out_ready;
                emit_dec  = out_ready;
                if (out_ready && emit_is_one) begin
                    state_next = FIN;
                end
            end

            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
